// File: rtl/cia_icr.sv
// CIA interrupt control register: latches source pulses into flags, applies the mask, drives /IRQ.
// Optional CIA_ICR_TB_BUG_EN: old-6526 behaviour where a TB underflow coinciding with an ICR read is lost.
module cia_icr #(
  parameter int NSRC = 5
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            phi2_dn,
  input  logic            rd,
  input  logic            w,
  input  logic [7:0]      data,
  input  logic [NSRC-1:0] src,
  output logic [7:0]      regs,
  output logic            irq_n
);

  logic [NSRC-1:0] flags;
  logic [NSRC-1:0] mask;
  logic            ir;

  logic [NSRC-1:0] src_eff;
  logic [NSRC-1:0] flags_kept;
  logic [NSRC-1:0] flags_next;
  logic [NSRC-1:0] mask_next;
  logic            ir_next;
  logic [6:0]      flags_wide;
  logic            unused_data_bits;

  assign unused_data_bits = &{1'b0, data[6:NSRC]};

  // A read discards the old flags before the new sources are or-ed in, so a
  // source active during the read survives; ir likewise only sees uncleared flags.
  always_comb begin
    src_eff = src;
`ifdef CIA_ICR_TB_BUG_EN
    src_eff[1] = src[1] & ~rd;
`endif
    flags_kept = rd ? '0 : flags;
    flags_next = flags_kept | src_eff;
    mask_next  = mask;
    if (w) begin
      if (data[7]) mask_next = mask | data[NSRC-1:0];
      else         mask_next = mask & ~data[NSRC-1:0];
    end
    ir_next    = (rd ? 1'b0 : ir) | (|(flags_kept & mask));
    flags_wide = 7'(flags);
  end

  assign regs = {ir, flags_wide};

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      flags <= '0;
      mask  <= '0;
      ir    <= 1'b0;
      irq_n <= 1'b1;
    end else if (phi2_dn) begin
      flags <= flags_next;
      mask  <= mask_next;
      ir    <= ir_next;
      irq_n <= ~ir_next;
    end
  end

endmodule

// File: tb/tb_cia_icr.sv
// Directed, table-driven bench for cia_icr plus hand sequences for reset and hold.
module tb_cia_icr;

  logic       clk;
  logic       res_n;
  logic       phi2_dn;
  logic       rd;
  logic       w;
  logic [7:0] data;
  logic [4:0] src;
  logic [7:0] regs;
  logic       irq_n;

  int total;
  int bad;

  typedef struct {
    logic       rd;
    logic       w;
    logic [7:0] data;
    logic [4:0] src;
    logic [7:0] exp_regs;
    logic       exp_irq_n;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

`ifdef CIA_ICR_TB_BUG_EN
  localparam logic [7:0] RACE_REGS = 8'h00;
`else
  localparam logic [7:0] RACE_REGS = 8'h02;
`endif

  cia_icr #(.NSRC(5)) dut (
    .clk     (clk),
    .res_n   (res_n),
    .phi2_dn (phi2_dn),
    .rd      (rd),
    .w       (w),
    .data    (data),
    .src     (src),
    .regs    (regs),
    .irq_n   (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // One PHI2 cycle: inputs held for one clk with the strobe high, then released.
  task automatic applyStimulus(input logic r, input logic wr, input logic [7:0] d,
                               input logic [4:0] s);
    @(negedge clk);
    rd = r; w = wr; data = d; src = s; phi2_dn = 1'b1;
    @(negedge clk);
    phi2_dn = 1'b0; rd = 1'b0; w = 1'b0; data = 8'h00; src = 5'h00;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_regs,
                             input logic exp_irq_n);
    total++;
    if (regs !== exp_regs || irq_n !== exp_irq_n) begin
      bad++;
      $display("[TB] FAIL %s: regs=%02h irq_n=%b, expected regs=%02h irq_n=%b",
               name, regs, irq_n, exp_regs, exp_irq_n);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    res_n = 1'b0; phi2_dn = 1'b0; rd = 1'b0; w = 1'b0; data = 8'h00; src = 5'h00;

    //            rd    w     data   src     regs   irq_n
    vecs[0]  = '{1'b0, 1'b1, 8'h81, 5'h00, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 5'h01, 8'h01, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h81, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 5'h00, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 5'h10, 8'h10, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h10, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'h90, 5'h00, 8'h10, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h90, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h10, 5'h00, 8'h90, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h90, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 5'h00, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 5'h02, RACE_REGS, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 5'h00, 8'h00, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 8'h01, 5'h00, 8'h00, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 8'hE4, 5'h00, 8'h00, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 5'h1F, 8'h1F, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h9F, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 5'h08, 8'h08, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h08, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 8'h88, 5'h00, 8'h00, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 5'h08, 8'h08, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h88, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 8'h00, 5'h00, 8'h00, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 5'h01, 8'h01, 1'b1};
    vecs[24] = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h01, 1'b1};
    vecs[25] = '{1'b0, 1'b1, 8'h81, 5'h00, 8'h01, 1'b1};
    vecs[26] = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h81, 1'b0};
    vecs[27] = '{1'b1, 1'b0, 8'h00, 5'h00, 8'h00, 1'b1};
    vecs[28] = '{1'b1, 1'b0, 8'h00, 5'h01, 8'h01, 1'b1};
    vecs[29] = '{1'b0, 1'b0, 8'h00, 5'h00, 8'h81, 1'b0};
    vecs[30] = '{1'b1, 1'b0, 8'h00, 5'h00, 8'h00, 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("reset_state", 8'h00, 1'b1);
    res_n = 1'b1;
    @(negedge clk);
    checkOutput("after_release", 8'h00, 1'b1);

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].rd) checkOutput($sformatf("vec%0d_preread", i), regs, irq_n);
      applyStimulus(vecs[i].rd, vecs[i].w, vecs[i].data, vecs[i].src);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_regs, vecs[i].exp_irq_n);
    end

    // Read returns the pre-clear value combinationally while rd is driven.
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h04);
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00);
    @(negedge clk);
    rd = 1'b1;
    #1;
    checkOutput("read_returns_preclear", 8'h84, 1'b0);
    rd = 1'b0;

    // Without a strobe nothing moves, whatever the other inputs do.
    rd = 1'b1; w = 1'b1; data = 8'h1F; src = 5'h1F;
    repeat (4) @(negedge clk);
    checkOutput("hold_without_strobe", 8'h84, 1'b0);
    rd = 1'b0; w = 1'b0; data = 8'h00; src = 5'h00;
    applyStimulus(1'b1, 1'b0, 8'h00, 5'h00);
    checkOutput("clear_after_hold", 8'h00, 1'b1);

    // Reset asserted mid-cycle with everything armed.
    applyStimulus(1'b0, 1'b1, 8'h9F, 5'h03);
    checkOutput("armed_flags", 8'h03, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00);
    checkOutput("armed_irq", 8'h83, 1'b0);
    @(posedge clk);
    #2;
    res_n = 1'b0;
    #1;
    checkOutput("reset_midcycle", 8'h00, 1'b1);
    @(negedge clk);
    res_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_released", 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00);
    checkOutput("reset_mask_cleared", 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 5'h00);
    checkOutput("reset_mask_stays_clear", 8'h01, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
